// File: rtl/table_fsm.sv
// table_fsm: Moore FSM whose next state is read from a writable {input, state}-addressed table,
// with per-entry valid bits, illegal-transition recovery, hold enable and saturating step count.
module table_fsm #(
    parameter int SW = 3,
    parameter int IW = 1,
    parameter logic [SW-1:0] RESET_STATE = SW'(2),
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IW-1:0]    in,
    input  logic             wr_en,
    input  logic [SW+IW-1:0] wr_addr,
    input  logic [SW:0]      wr_data,
    output logic [SW-1:0]    state,
    output logic             changed,
    output logic             illegal,
    output logic [CW-1:0]    steps
);
    localparam int AW = SW + IW;
    localparam bit LEGACY = SW == 3 && IW == 1;

    function automatic logic [SW:0] legacy_entry(input logic [AW-1:0] a);
        logic b;
        b = a[SW];
        if (!LEGACY) return '0;
        case (int'(a[SW-1:0]))
            2: return {1'b1, SW'(6)};
            4: return {1'b1, b ? SW'(6) : SW'(2)};
            5: return {1'b1, SW'(4)};
            6: return {1'b1, b ? SW'(7) : SW'(5)};
            7: return {1'b1, SW'(5)};
            default: return '0;
        endcase
    endfunction

    // Entries are stored XORed with the legacy contents, so all-zero power-up storage reads back as the legacy table.
    logic [SW:0]    tbl [1 << AW];
    logic [AW-1:0]  rd_addr;
    logic [SW:0]    entry;
    logic [SW-1:0]  state_d;
    logic           changed_d;
    logic           illegal_d;
    logic [CW-1:0]  steps_d;

    assign rd_addr = {in, state};
    assign entry = tbl[rd_addr] ^ legacy_entry(rd_addr);

    always_ff @(posedge clk)
        if (wr_en) tbl[wr_addr] <= wr_data ^ legacy_entry(wr_addr);

    always_comb begin
        state_d = state;
        changed_d = 1'b0;
        illegal_d = illegal;
        steps_d = steps;
        if (en) begin
            state_d = entry[SW] ? entry[SW-1:0] : RESET_STATE;
            changed_d = state_d != state;
            illegal_d = illegal | ~entry[SW];
            steps_d = &steps ? steps : steps + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            state <= RESET_STATE;
            changed <= 1'b0;
            illegal <= 1'b0;
            steps <= '0;
        end else begin
            state <= state_d;
            changed <= changed_d;
            illegal <= illegal_d;
            steps <= steps_d;
        end
endmodule

// File: tb/tb_table_fsm.sv
// tb_table_fsm: directed and random checks of table_fsm against an array-based transition model.
module tb_table_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r1 = 0, e1 = 0, i1 = 0, w1 = 0;
    logic [3:0] wa1 = '0, wd1 = '0, st1;
    logic [2:0] s1;
    logic c1, il1;
    logic r2 = 0, e2 = 0, w2 = 0;
    logic [1:0] i2 = '0;
    logic [5:0] wa2 = '0;
    logic [4:0] wd2 = '0;
    logic [3:0] s2, st2;
    logic c2, il2;

    table_fsm dut1 (
        .clk(clk), .reset(r1), .en(e1), .in(i1), .wr_en(w1), .wr_addr(wa1), .wr_data(wd1),
        .state(s1), .changed(c1), .illegal(il1), .steps(st1)
    );
    table_fsm #(.SW(4), .IW(2), .RESET_STATE(4'd9), .CW(4)) dut2 (
        .clk(clk), .reset(r2), .en(e2), .in(i2), .wr_en(w2), .wr_addr(wa2), .wr_data(wd2),
        .state(s2), .changed(c2), .illegal(il2), .steps(st2)
    );

    int n_cmp = 0, n_bad = 0;
    int mv [2][64];
    int mn [2][64];
    int ms [2], mc [2], mi [2], mk [2];
    int o_s, o_c, o_i, o_k;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rst_of(input int u);
        return u ? 9 : 2;
    endfunction

    // One clock cycle on unit u (0: default build, 1: SW=4/IW=2 build); the other unit idles.
    task automatic cyc(input int u, input bit rst, input bit en, input int iv, input bit we, input int wa, input int wd);
        int a, nx, w;
        w = u ? 4 : 3;
        {r1, e1, w1} = u == 0 ? {rst, en, we} : 3'b0;
        {r2, e2, w2} = u == 1 ? {rst, en, we} : 3'b0;
        i1 = 1'(iv); wa1 = 4'(wa); wd1 = 4'(wd);
        i2 = 2'(iv); wa2 = 6'(wa); wd2 = 5'(wd);
        @(posedge clk);
        if (rst) begin
            ms[u] = rst_of(u); mc[u] = 0; mi[u] = 0; mk[u] = 0;
        end else if (en) begin
            a = iv * (1 << w) + ms[u];
            nx = mv[u][a] != 0 ? mn[u][a] : rst_of(u);
            mc[u] = nx != ms[u] ? 1 : 0;
            if (mv[u][a] == 0) mi[u] = 1;
            mk[u] = mk[u] < 15 ? mk[u] + 1 : 15;
            ms[u] = nx;
        end else mc[u] = 0;
        if (we) begin
            mv[u][wa] = wd >> w;
            mn[u][wa] = wd % (1 << w);
        end
        #1;
        o_s = u ? int'(s2) : int'(s1);
        o_c = u ? int'(c2) : int'(c1);
        o_i = u ? int'(il2) : int'(il1);
        o_k = u ? int'(st2) : int'(st1);
        check("model_state", o_s, ms[u]);
        check("model_changed", o_c, mc[u]);
        check("model_illegal", o_i, mi[u]);
        check("model_steps", o_k, mk[u]);
    endtask

    task automatic set0(input int a, input int n);
        mv[0][a] = 1;
        mn[0][a] = n;
    endtask

    int w0 [4] = '{6, 5, 4, 2};
    int w1s [5] = '{6, 7, 5, 4, 6};
    int exp_s;

    initial begin
        for (int b = 0; b < 2; b++) begin
            set0(b * 8 + 2, 6);
            set0(b * 8 + 5, 4);
            set0(b * 8 + 7, 5);
            set0(b * 8 + 4, b ? 6 : 2);
            set0(b * 8 + 6, b ? 7 : 5);
        end
        cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0);
        check("rst_state", int'(s1), 2);
        check("rst_changed", int'(c1), 0);
        check("rst_illegal", int'(il1), 0);
        check("rst_steps", int'(st1), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            check("walk0_state", int'(s1), w0[k]);
            check("walk0_changed", int'(c1), 1);
            check("walk0_steps", int'(st1), k + 1);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 1, 0, 0, 0);
            check("walk1_state", int'(s1), w1s[k]);
            check("walk1_steps", int'(st1), k + 1);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            check("hold_state", int'(s1), 6);
            check("hold_steps", int'(st1), 5);
            check("hold_changed", int'(c1), 0);
        end
        for (int k = 0; k < 20; k++) cyc(0, 0, 1, 1, 0, 0, 0);
        check("sat_steps", int'(st1), 15);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("sat_stay", int'(st1), 15);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 4'b0110);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("ill_state", int'(s1), 2);
        check("ill_flag", int'(il1), 1);
        check("ill_changed", int'(c1), 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("ill_sticky_state", int'(s1), 7);
        check("ill_sticky", int'(il1), 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 8 + 6, 4'b1011);
        check("coll_old", int'(s1), 7);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 0, 0, 0);
        check("coll_at6", int'(s1), 6);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("coll_new", int'(s1), 3);
        cyc(0, 0, 0, 0, 1, 8 + 6, 4'b1111);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("rw_at7", int'(s1), 7);
        cyc(0, 1, 1, 1, 1, 2, 4'b1101);
        check("rw_state", int'(s1), 2);
        check("rw_steps", int'(st1), 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("rw_landed", int'(s1), 5);
        for (int k = 0; k < 300; k++)
            cyc(0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15));

        cyc(1, 1, 0, 0, 0, 0, 0);
        check("p_rst_state", int'(s2), 9);
        cyc(1, 0, 1, 2, 0, 0, 0);
        check("p_unprog_state", int'(s2), 9);
        check("p_unprog_illegal", int'(il2), 1);
        for (int a = 0; a < 64; a++) cyc(1, 0, 0, 0, 1, a, 16 | ((a % 16 + 1) % 16));
        cyc(1, 1, 0, 0, 0, 0, 0);
        exp_s = 9;
        for (int k = 0; k < 40; k++) begin
            cyc(1, 0, 1, $urandom_range(0, 3), 0, 0, 0);
            exp_s = (exp_s + 1) % 16;
            check("p_cnt_state", int'(s2), exp_s);
        end
        check("p_cnt_legal", int'(il2), 0);
        for (int k = 0; k < 200; k++)
            cyc(1, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                $urandom_range(0, 7) == 0, $urandom_range(0, 63), $urandom_range(0, 31));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
